// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder_pkg
// Description : Shared types and configuration helpers for the sequential
//               chunked adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_chunk_adder_pkg;

    // Operation phases of the chunked adder
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the operand width splits into a whole number of chunks
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        if (chunk < 1) begin
            return 1'b0;
        end
        if (width < chunk) begin
            return 1'b0;
        end
        return (width % chunk) == 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_ripple.sv
`default_nettype none
// ============================================================================
// Module      : chunk_ripple_adder
// Description : Combinational CHUNK-bit ripple of full-adder cells. Exposes
//               the carry into the top bit so the caller can derive signed
//               overflow on the final chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // w_c[i] is the carry into bit i; w_c[CHUNK] leaves the chunk
    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < CHUNK; i++) begin : g_fa
            assign s[i]     = x[i] ^ y[i] ^ w_c[i];
            assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    endgenerate

    assign co    = w_c[CHUNK];
    assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder
// Description : Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits
//               per clock, LSB chunk first, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCH - 1);

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
            $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  w_s;
    logic              w_co;
    logic              w_c_msb;
    logic [WIDTH-1:0]  w_a_shift;
    logic [WIDTH-1:0]  w_b_shift;
    logic [WIDTH-1:0]  w_res_shift;

    // The current chunk always sits in the low bits of the operand registers
    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (a_q[CHUNK-1:0]),
        .y     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (w_s),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    // Operands shift down one chunk per cycle; results enter from the top so
    // the first chunk ends up in the LSBs after NCH steps
    generate
        if (NCH == 1) begin : g_single
            assign w_a_shift   = a_q;
            assign w_b_shift   = b_q;
            assign w_res_shift = w_s;
        end else begin : g_multi
            assign w_a_shift   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
            assign w_b_shift   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
            assign w_res_shift = {w_s, res_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Next-state logic: operand capture, chunk stepping and result commit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = w_a_shift;
                b_d     = w_b_shift;
                res_d   = w_res_shift;
                carry_d = w_co;
                if (idx_q == C_LAST_IDX) begin
                    sum_d   = w_res_shift;
                    cout_d  = w_co;
                    ovf_d   = w_co ^ w_c_msb;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_chunk_adder
// Description : Scoreboard bench for seq_chunk_adder with CHUNK=4, 1 and 16
//               instances sharing operand inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start1, start16;
    logic [15:0] a, b;
    logic        cin, sub;

    logic        busy4, done4, cout4, ovf4;
    logic        busy1, done1, cout1, ovf1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum4, sum1, sum16;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bcnt [3];
    exp_t q4[$];
    exp_t q1[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    // Cycle counter: cycle k spans posedge k to posedge k+1
    always @(posedge clk) cyc <= cyc + 1;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, id, cyc, act, exp);
        end
    endtask

    // Monitor one instance: count busy cycles and score each done pulse
    task automatic mon(input int id, input logic dn, input logic bs, input logic [15:0] s,
                       input logic co, input logic ov, input int nch);
        exp_t e;
        bit   have;
        if (rst) begin
            bcnt[id] = 0;
            return;
        end
        if (bs) bcnt[id]++;
        if (dn) begin
            have = 1'b0;
            case (id)
                0: if (q4.size()  > 0) begin e = q4.pop_front();  have = 1'b1; end
                1: if (q1.size()  > 0) begin e = q1.pop_front();  have = 1'b1; end
                default: if (q16.size() > 0) begin e = q16.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done dut%0d: done=1 at cycle %0d, expected no done", id, cyc);
            end else begin
                chk("sum",        id, {16'h0, s},  {16'h0, e.sum});
                chk("cout",       id, {31'h0, co}, {31'h0, e.cout});
                chk("ovf",        id, {31'h0, ov}, {31'h0, e.ovf});
                chk("done_cycle", id, cyc,         e.cyc);
                chk("busy_count", id, bcnt[id],    nch);
            end
            bcnt[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, done4,  busy4,  sum4,  cout4,  ovf4,  4);
        mon(1, done1,  busy1,  sum1,  cout1,  ovf1,  16);
        mon(2, done16, busy16, sum16, cout16, ovf16, 1);
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one start in the current cycle; optionally push the expectation
    task automatic go(input int id, input logic [15:0] va, input logic [15:0] vb,
                      input logic vcin, input logic vsub, input bit push,
                      input logic [15:0] es, input logic ec, input logic eo,
                      output int acc);
        exp_t e;
        int   nch;
        nch = (id == 0) ? 4 : ((id == 1) ? 16 : 1);
        a   = va;
        b   = vb;
        cin = vcin;
        sub = vsub;
        acc = cyc;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + nch + 1;
        if (push) begin
            case (id)
                0: q4.push_back(e);
                1: q1.push_back(e);
                default: q16.push_back(e);
            endcase
        end
        case (id)
            0: start4 = 1'b1;
            1: start1 = 1'b1;
            default: start16 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        a = $urandom(); b = $urandom(); cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 0, {31'h0, busy4}, 0);
        chk("reset_done", 0, {31'h0, done4}, 0);
        chk("reset_sum",  0, {16'h0, sum4},  0);
        chk("reset_cout", 0, {31'h0, cout4}, 0);
        chk("reset_ovf",  0, {31'h0, ovf4},  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic adds, carry-out and signed overflow
        go(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, 1'b0, acc); wait_until(acc + 7);
        go(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, acc); wait_until(acc + 7);
        go(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1, 16'h8000, 1'b0, 1'b1, acc); wait_until(acc + 7);
        // Subtracts; cin=1 must be ignored
        go(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0, acc); wait_until(acc + 7);
        go(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, acc); wait_until(acc + 7);
        go(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1, 16'h0000, 1'b1, 1'b0, acc); wait_until(acc + 7);

        // Start while busy is ignored; start during done is accepted
        go(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0, acc);
        wait_until(acc + 2);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_until(acc + 5);
        go(0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1, 16'h1000, 1'b0, 1'b0, acc);
        wait_until(acc + 7);

        // Reset mid-operation aborts with no done pulse
        go(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, acc);
        wait_until(acc + 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 0, {31'h0, busy4}, 0);
        chk("abort_done", 0, {31'h0, done4}, 0);
        chk("abort_sum",  0, {16'h0, sum4},  0);
        chk("abort_cout", 0, {31'h0, cout4}, 0);
        chk("abort_ovf",  0, {31'h0, ovf4},  0);
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end

        // Bit-serial and single-chunk configurations
        go(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, 1'b0, acc); wait_until(acc + 19);
        go(2, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, 16'h5555, 1'b0, 1'b0, acc); wait_until(acc + 4);
        go(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, acc); wait_until(acc + 19);
        go(2, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1, 16'h8000, 1'b0, 1'b1, acc); wait_until(acc + 4);

        repeat (4) begin @(posedge clk); #1; end
        chk("pending_dut4",  0, q4.size(),  0);
        chk("pending_dut1",  1, q1.size(),  0);
        chk("pending_dut16", 2, q16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
